shift_arbiter: RTL and testbench

- Shares one 32-bit shift datapath (SLL/SRL/SRA, 5-bit shift amount) between NUM_REQ requesters, e.g. the ALU issue path, the CSR/debug path and a load-align path.
- Round-robin arbitration over valid/ready request channels.
- One registered response slot with valid/ready handshake, tagged with the requester ID.
- Sits between the requesters and the writeback mux; the shift logic itself is a combinational sub-module.

---
 rtl/shift_pkg.sv | 14 +
 rtl/shift_unit.sv | 22 ++
 rtl/shift_arbiter.sv | 101 ++++++++++
 tb/tb_shift_arbiter.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types and widths for the shift arbiter and its shift unit.
package shift_pkg;

    localparam int XLEN    = 32;
    localparam int SHAMT_W = 5;

    typedef enum logic [1:0] {
        SHIFT_SLL  = 2'b00,
        SHIFT_SRL  = 2'b01,
        SHIFT_SRA  = 2'b10,
        SHIFT_PASS = 2'b11
    } shift_op_e;

endpackage

// File: rtl/shift_unit.sv
// Combinational 32-bit barrel shifter: SLL, SRL, SRA (sign fill) and pass-through.
module shift_unit
    import shift_pkg::*;
(
    input  logic [XLEN-1:0]    a,
    input  logic [SHAMT_W-1:0] shamt,
    input  shift_op_e          op,
    output logic [XLEN-1:0]    y
);

    always_comb begin
        y = a;
        case (op)
            SHIFT_SLL:  y = a << shamt;
            SHIFT_SRL:  y = a >> shamt;
            SHIFT_SRA:  y = $unsigned($signed(a) >>> shamt);
            SHIFT_PASS: y = a;
            default:    y = a;
        endcase
    end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one shift unit among NUM_REQ requesters, with a
// single registered response slot. Define SHIFT_ARB_STATS_EN to add stat_stall_o.
module shift_arbiter
    import shift_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    input  logic [NUM_REQ*XLEN-1:0]   req_data_i,
    input  logic [NUM_REQ*SHAMT_W-1:0] req_shamt_i,
    input  logic [NUM_REQ*2-1:0]      req_op_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [XLEN-1:0]           rsp_data_o,
    output logic [ID_W-1:0]           rsp_id_o
`ifdef SHIFT_ARB_STATS_EN
    ,
    output logic [15:0]               stat_stall_o
`endif
);

    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    win;
    logic [ID_W:0]      cand;
    logic               found;
    logic               slot_free;
    logic               transfer;
    logic [XLEN-1:0]    shift_y;
    logic [XLEN-1:0]    win_a;
    logic [SHAMT_W-1:0] win_shamt;
    shift_op_e          win_op;

    assign slot_free = !rsp_valid_o || rsp_ready_i;

    // Scan from rr_ptr upward, wrapping; first valid requester wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, rr_ptr} + (ID_W+1)'(i);
            if (cand >= (ID_W+1)'(NUM_REQ)) begin
                cand = cand - (ID_W+1)'(NUM_REQ);
            end
            if (!found && req_valid_i[cand[ID_W-1:0]]) begin
                found = 1'b1;
                win   = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        if (found && slot_free && !rst_i) begin
            req_ready_o = NUM_REQ'(1) << win;
        end
    end

    assign transfer  = |(req_valid_i & req_ready_o);
    assign win_a     = req_data_i[win*XLEN +: XLEN];
    assign win_shamt = req_shamt_i[win*SHAMT_W +: SHAMT_W];
    assign win_op    = shift_op_e'(req_op_i[win*2 +: 2]);

    shift_unit u_shift (
        .a     (win_a),
        .shamt (win_shamt),
        .op    (win_op),
        .y     (shift_y)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_valid_o <= 1'b0;
            rsp_data_o  <= '0;
            rsp_id_o    <= '0;
            rr_ptr      <= '0;
        end else if (transfer) begin
            rsp_valid_o <= 1'b1;
            rsp_data_o  <= shift_y;
            rsp_id_o    <= win;
            rr_ptr      <= (win == ID_W'(NUM_REQ-1)) ? '0 : win + 1'b1;
        end else if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
        end
    end

`ifdef SHIFT_ARB_STATS_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stat_stall_o <= '0;
        end else if (|req_valid_i && !transfer && stat_stall_o != 16'hFFFF) begin
            stat_stall_o <= stat_stall_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed self-checking bench for shift_arbiter (NUM_REQ=4).
`timescale 1ns/1ps
module tb_shift_arbiter;
    localparam int N = 4;

    logic           clk_i = 1'b0;
    logic           rst_i;
    logic [N-1:0]   req_valid_i;
    logic [N-1:0]   req_ready_o;
    logic [N*32-1:0] req_data_i;
    logic [N*5-1:0] req_shamt_i;
    logic [N*2-1:0] req_op_i;
    logic           rsp_valid_o;
    logic           rsp_ready_i;
    logic [31:0]    rsp_data_o;
    logic [1:0]     rsp_id_o;
`ifdef SHIFT_ARB_STATS_EN
    logic [15:0]    stat_stall_o;
`endif

    int checks = 0;
    int errors = 0;

    shift_arbiter #(.NUM_REQ(N)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_data_i  (req_data_i),
        .req_shamt_i (req_shamt_i),
        .req_op_i    (req_op_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_data_o  (rsp_data_o),
        .rsp_id_o    (rsp_id_o)
`ifdef SHIFT_ARB_STATS_EN
        ,
        .stat_stall_o(stat_stall_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int k, input logic v, input logic [31:0] a,
                           input logic [4:0] sh, input logic [1:0] op);
        req_valid_i[k]       = v;
        req_data_i[k*32 +: 32] = a;
        req_shamt_i[k*5 +: 5]  = sh;
        req_op_i[k*2 +: 2]     = op;
    endtask

    // Advance one clock and land on the following falling edge.
    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    // Issue one lone request, then check the registered response.
    task automatic single(input string tag, input int k, input logic [31:0] a,
                          input logic [4:0] sh, input logic [1:0] op, input logic [31:0] exp);
        req_valid_i = '0;
        set_req(k, 1'b1, a, sh, op);
        #1;
        chk({tag, "_ready"}, 32'(req_ready_o), 32'(1 << k));
        step();
        chk({tag, "_data"}, rsp_data_o, exp);
        chk({tag, "_id"}, 32'(rsp_id_o), 32'(k));
        req_valid_i = '0;
    endtask

    initial begin
        rst_i       = 1'b1;
        rsp_ready_i = 1'b1;
        req_valid_i = '0;
        req_data_i  = '0;
        req_shamt_i = '0;
        req_op_i    = '0;
        for (int k = 0; k < N; k++) set_req(k, 1'b1, 32'h1111_1111 * (k + 1), 5'd0, 2'b11);

        // Reset held two cycles with everybody valid
        @(negedge clk_i);
        step();
        chk("rst_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst_ready", 32'(req_ready_o), 32'd0);
        chk("rst_data", rsp_data_o, 32'd0);
        chk("rst_id", 32'(rsp_id_o), 32'd0);
        rst_i = 1'b0;

        // Round-robin with all valid: 0,1,2,3,0
        for (int g = 0; g < 5; g++) begin
            #1;
            chk("rr_ready", 32'(req_ready_o), 32'(1 << (g % N)));
            step();
            chk("rr_valid", 32'(rsp_valid_o), 32'd1);
            chk("rr_id", 32'(rsp_id_o), 32'(g % N));
            chk("rr_data", rsp_data_o, 32'h1111_1111 * ((g % N) + 1));
        end

        // Idle with consumer ready: slot empties, data held
        req_valid_i = '0;
        step();
        chk("idle_valid", 32'(rsp_valid_o), 32'd0);
        chk("idle_data", rsp_data_o, 32'h1111_1111);

        single("sra1", 1, 32'h8000_0010, 5'd4, 2'b10, 32'hF800_0001);

        // Backpressure: result held 3 cycles while req2 waits
        rsp_ready_i = 1'b0;
        set_req(2, 1'b1, 32'h0000_0001, 5'd31, 2'b00);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_ready", 32'(req_ready_o), 32'd0);
            step();
            chk("bp_valid", 32'(rsp_valid_o), 32'd1);
            chk("bp_data", rsp_data_o, 32'hF800_0001);
            chk("bp_id", 32'(rsp_id_o), 32'd1);
        end
        rsp_ready_i = 1'b1;
        #1;
        chk("bp_release_ready", 32'(req_ready_o), 32'b0100);
        step();
        chk("bp_sll31_data", rsp_data_o, 32'h8000_0000);
        chk("bp_sll31_id", 32'(rsp_id_o), 32'd2);
        chk("bp_sll31_valid", 32'(rsp_valid_o), 32'd1);
        req_valid_i = '0;

        // Shift boundaries (pointer now at 3)
        single("srl31", 3, 32'hFFFF_FFFF, 5'd31, 2'b01, 32'h0000_0001);
        single("sra31_pos", 0, 32'h7FFF_FFFF, 5'd31, 2'b10, 32'h0000_0000);
        single("pass", 1, 32'hDEAD_BEEF, 5'd7, 2'b11, 32'hDEAD_BEEF);
        single("sra31_neg", 2, 32'h8000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF);
        single("sll0", 3, 32'h1234_5678, 5'd0, 2'b00, 32'h1234_5678);
        single("srl8", 0, 32'hA5A5_0000, 5'd8, 2'b01, 32'h00A5_A500);

        // Mid-operation reset: pointer is 1, slot full
        rsp_ready_i = 1'b0;
        rst_i       = 1'b1;
        set_req(0, 1'b1, 32'hCAFE_0000, 5'd0, 2'b11);
        set_req(2, 1'b1, 32'h0000_BEEF, 5'd0, 2'b11);
        step();
        chk("mid_rst_valid", 32'(rsp_valid_o), 32'd0);
        chk("mid_rst_data", rsp_data_o, 32'd0);
        rst_i       = 1'b0;
        rsp_ready_i = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(req_ready_o), 32'b0001);
        step();
        chk("mid_rst_id", 32'(rsp_id_o), 32'd0);
        chk("mid_rst_data2", rsp_data_o, 32'hCAFE_0000);
        req_valid_i = '0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
